// File: rtl/alu_dispatch_if.sv
// alu_dispatch_if: request, unit and result signals between a dispatcher and its client/units
interface alu_dispatch_if #(parameter int RES_W = 32);
   logic op_valid;
   logic op_ready;
   logic [10:0] op_sel;
   logic [10:0] unit_start;
   logic [10:0] unit_done;
   logic [11*RES_W-1:0] unit_result;
   logic [RES_W-1:0] result;
   logic result_float;
   logic result_valid;
   logic result_ack;
   logic error;
   logic busy;
   modport master (
      output op_valid, op_sel, unit_done, unit_result, result_ack,
      input  op_ready, unit_start, result, result_float, result_valid, error, busy
   );
   modport slave (
      input  op_valid, op_sel, unit_done, unit_result, result_ack,
      output op_ready, unit_start, result, result_float, result_valid, error, busy
   );
endinterface

// File: rtl/alu_dispatch.sv
// alu_dispatch: issues one-hot opcodes to eleven arithmetic units and returns the selected result
module alu_dispatch #(
   parameter int RES_W = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic CLK100MHz,
   input logic reset_n,
   input logic abort,
   alu_dispatch_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [10:0] FLOAT_OPS = 11'b00011111101;
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, ERR} state_t;
   state_t state, state_nx;
   logic [10:0] op_q;
   logic [TW-1:0] timer;
   logic [RES_W-1:0] sel_res;
   logic hit;
   assign hit = |(bus.unit_done & op_q);
   always_comb begin
      sel_res = '0;
      for (int i = 0; i < 11; i++)
         sel_res = op_q[i] ? sel_res | bus.unit_result[i*RES_W +: RES_W] : sel_res;
   end
   always_comb begin
      state_nx = state;
      if (abort)
         state_nx = IDLE;
      else
         case (state)
            IDLE:     state_nx = bus.op_valid ? ($onehot(bus.op_sel) ? ISSUE : ERR) : IDLE;
            ISSUE:    state_nx = WAIT;
            WAIT:     state_nx = hit ? HOLD : (timer == TW'(TIMEOUT_CYCLES - 1) ? ERR : WAIT);
            HOLD,
            ERR:      state_nx = bus.result_ack ? IDLE : state;
            default:  state_nx = IDLE;
         endcase
   end
   // outputs are registered from the next state so they change together with it
   always_ff @(posedge CLK100MHz or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         op_q <= '0;
         timer <= '0;
         bus.unit_start <= '0;
         bus.op_ready <= 1'b1;
         bus.busy <= 1'b0;
         bus.result_valid <= 1'b0;
         bus.error <= 1'b0;
         bus.result <= '0;
         bus.result_float <= 1'b0;
      end else begin
         state <= state_nx;
         op_q <= (state == IDLE && bus.op_valid) ? bus.op_sel : op_q;
         timer <= (state == WAIT) ? timer + 1'b1 : '0;
         bus.unit_start <= (state_nx == ISSUE) ? bus.op_sel : '0;
         bus.op_ready <= state_nx == IDLE;
         bus.busy <= state_nx != IDLE;
         bus.result_valid <= state_nx == HOLD || state_nx == ERR;
         bus.error <= state_nx == ERR;
         if (state == WAIT && state_nx == HOLD) begin
            bus.result <= sel_res;
            bus.result_float <= |(op_q & FLOAT_OPS);
         end else if (state_nx == ERR) begin
            bus.result <= '0;
            bus.result_float <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_alu_dispatch.sv
// tb_alu_dispatch: vector table over all opcode classes plus timeout, abort and reset sequences
module tb_alu_dispatch;
   localparam int RW = 32;
   logic CLK100MHz = 1'b0;
   logic reset_n = 1'b1;
   logic abort = 1'b0;
   always #5 CLK100MHz = ~CLK100MHz;
   alu_dispatch_if #(.RES_W(RW)) bus ();
   alu_dispatch #(.RES_W(RW), .TIMEOUT_CYCLES(8)) dut (
      .CLK100MHz(CLK100MHz),
      .reset_n(reset_n),
      .abort(abort),
      .bus(bus)
   );
   int checks = 0;
   int failures = 0;
   typedef struct {
      logic [10:0] sel;
      int idx;
      int dly;
      logic [31:0] val;
      logic flt;
      logic err;
   } vec_t;
   vec_t v[10];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic step();
      @(posedge CLK100MHz);
      #1;
   endtask
   task automatic fill();
      for (int i = 0; i < 11; i++) bus.unit_result[i*RW +: RW] = 32'hDEAD0000 | i;
   endtask
   task automatic start(input logic [10:0] sel);
      bus.op_sel = sel;
      bus.op_valid = 1'b1;
      step();
      bus.op_valid = 1'b0;
   endtask
   task automatic done(input int idx, input logic [31:0] val);
      bus.unit_result[idx*RW +: RW] = val;
      bus.unit_done[idx] = 1'b1;
      step();
      bus.unit_done = '0;
   endtask
   task automatic ack();
      bus.result_ack = 1'b1;
      step();
      bus.result_ack = 1'b0;
   endtask
   initial begin
      v[0] = '{11'b10000000000, 10, 3, 32'd25, 1'b0, 1'b0};
      v[1] = '{11'b01000000000, 9, 0, 32'hFFFFFFFF, 1'b0, 1'b0};
      v[2] = '{11'b00100000000, 8, 2, 32'h12345678, 1'b0, 1'b0};
      v[3] = '{11'b00010000000, 7, 1, 32'hABCD0001, 1'b1, 1'b0};
      v[4] = '{11'b00000100000, 5, 5, 32'h00008000, 1'b1, 1'b0};
      v[5] = '{11'b00000000010, 1, 4, 32'h00000400, 1'b0, 1'b0};
      v[6] = '{11'b00000000001, 0, 6, 32'h0002B7E1, 1'b1, 1'b0};
      v[7] = '{11'b00000000100, 2, 0, 32'hFFFF0000, 1'b1, 1'b0};
      v[8] = '{11'b00000000011, 0, 0, 32'h0, 1'b0, 1'b1};
      v[9] = '{11'b00000000000, 0, 0, 32'h0, 1'b0, 1'b1};
      bus.op_valid = 1'b0;
      bus.op_sel = '0;
      bus.unit_done = '0;
      bus.result_ack = 1'b0;
      fill();
      #2 reset_n = 1'b0;
      #1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_valid", bus.result_valid, 0);
      chk("rst_error", bus.error, 0);
      chk("rst_start", bus.unit_start, 0);
      chk("rst_result", bus.result, 0);
      chk("rst_float", bus.result_float, 0);
      step();
      step();
      reset_n = 1'b1;
      step();
      chk("rst_ready", bus.op_ready, 1);
      for (int k = 0; k < 10; k++) begin
         fill();
         start(v[k].sel);
         chk($sformatf("v%0d_start", k), bus.unit_start, v[k].err ? 11'b0 : v[k].sel);
         chk($sformatf("v%0d_busy", k), {bus.busy, bus.op_ready}, 2'b10);
         if (!v[k].err) begin
            step();
            chk($sformatf("v%0d_pulse", k), bus.unit_start, 0);
            repeat (v[k].dly) step();
            chk($sformatf("v%0d_early", k), bus.result_valid, 0);
            done(v[k].idx, v[k].val);
            chk($sformatf("v%0d_valid", k), {bus.result_valid, bus.error}, 2'b10);
            chk($sformatf("v%0d_result", k), bus.result, v[k].val);
            chk($sformatf("v%0d_float", k), bus.result_float, v[k].flt);
            step();
            chk($sformatf("v%0d_hold", k), {bus.result_valid, bus.result}, {1'b1, v[k].val});
         end else begin
            chk($sformatf("v%0d_err", k), {bus.result_valid, bus.error, bus.result_float}, 3'b110);
            chk($sformatf("v%0d_errres", k), bus.result, 0);
         end
         ack();
         chk($sformatf("v%0d_ack", k), {bus.result_valid, bus.error, bus.op_ready, bus.busy}, 4'b0010);
      end
      fill();
      start(11'b00001000000);
      step();
      done(10, 32'd99);
      chk("sqrt_spurious", {bus.result_valid, bus.busy}, 2'b01);
      done(6, 32'h00016A09);
      chk("sqrt_result", bus.result, 32'h00016A09);
      chk("sqrt_float", {bus.result_valid, bus.result_float}, 2'b11);
      ack();
      start(11'b00010000000);
      step();
      repeat (7) step();
      chk("to_not_yet", {bus.result_valid, bus.error}, 2'b00);
      step();
      chk("to_error", {bus.result_valid, bus.error}, 2'b11);
      chk("to_result", bus.result, 0);
      done(7, 32'h55);
      chk("to_late_done", {bus.result_valid, bus.error, bus.result}, {2'b11, 32'h0});
      ack();
      chk("to_ack", {bus.error, bus.op_ready}, 2'b01);
      start(11'b00010000000);
      step();
      repeat (7) step();
      done(7, 32'h77);
      chk("to_edge_done", {bus.result_valid, bus.error}, 2'b10);
      chk("to_edge_result", bus.result, 32'h77);
      ack();
      start(11'b00100000000);
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_idle", {bus.busy, bus.op_ready, bus.result_valid, bus.error}, 4'b0100);
      done(8, 32'h88);
      chk("abort_late", {bus.busy, bus.result_valid}, 2'b00);
      chk("abort_keep", bus.result, 32'h77);
      ack();
      chk("ack_idle", {bus.busy, bus.result_valid}, 2'b00);
      start(11'b10000000000);
      step();
      done(10, 32'd25);
      chk("rh_hold", bus.result_valid, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("rh_outputs", {bus.result_valid, bus.error, bus.busy, bus.result_float}, 4'b0000);
      chk("rh_result", bus.result, 0);
      chk("rh_start", bus.unit_start, 0);
      #2 reset_n = 1'b1;
      step();
      chk("rh_ready", {bus.op_ready, bus.busy, bus.unit_start}, {2'b10, 11'b0});
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
